nt_receiver_deframer: RTL

Downstream stage of the serial transmitter. It consumes the transmitter's serial data bit and valid strobe and treats each contiguous run of valid bits as one frame. Frames are packed MSB-first into WIDTH-bit words, tagged with bit count and end-of-frame, and buffered in a small FIFO. The FIFO is drained by a valid/ready consumer, with overflow and frame-count status.

---
 rtl/nt_receiver_deframer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/nt_receiver_deframer.sv
// ---------------------------------------------------------------------------
// nt_receiver_deframer
//
// Receive-side deframer for the serial transmitter. Each contiguous run of
// invalid=1 cycles is one frame. Bits arrive MSB-first and are packed into
// WIDTH-bit words. Each word is tagged with its bit count and an end-of-frame
// flag, then buffered in a small first-word-fall-through FIFO that a
// valid/ready consumer drains.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   serin      serial data bit (transmitter serout)
//   invalid    serial strobe (transmitter outvalid); serin sampled when high
//   out_data   head-of-FIFO word, left-aligned, low bits zero-padded
//   out_nbits  number of valid bits in out_data (1..WIDTH; 0 when empty)
//   out_last   head word ends a frame
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head word when out_valid is also high
//   overflow   sticky flag, set when a word is dropped on a full FIFO
//   clr_ovf    synchronous clear of overflow (a coincident drop wins)
//   frames_rx  wrapping count of frames whose last word entered the FIFO
// ---------------------------------------------------------------------------
module nt_receiver_deframer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8,
    localparam int NBW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serin,
    input  logic             invalid,
    output logic [WIDTH-1:0] out_data,
    output logic [NBW-1:0]   out_nbits,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [CNTW-1:0]  frames_rx
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + NBW + 1;
    localparam logic [WIDTH-1:0] MSB_ONE = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    // -----------------------------------------------------------------------
    // Assembler state
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [NBW-1:0]   bitcnt_q, bitcnt_d;

    // A completed full word waits here for one cycle: its last flag depends
    // on whether invalid is still high in the following cycle.
    logic             hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;

    // Push request register. Both the full-word and the partial-word paths
    // pass through it, which keeps the FIFO entry latency identical.
    logic             push_vld_q, push_vld_d;
    logic [WIDTH-1:0] push_data_q, push_data_d;
    logic [NBW-1:0]   push_nbits_q, push_nbits_d;
    logic             push_last_q, push_last_d;

    // -----------------------------------------------------------------------
    // FIFO state
    // -----------------------------------------------------------------------
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [NBW-1:0]   out_nbits_q, out_nbits_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [CNTW-1:0]  frames_q, frames_d;

    logic             pop;
    logic             full;
    logic             push_acc;
    logic             drop;
    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    head_entry;
    logic [WIDTH-1:0] shreg_ins;

    // -----------------------------------------------------------------------
    // Assembler next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        hold_vld_d   = 1'b0;
        hold_data_d  = hold_data_q;
        push_vld_d   = 1'b0;
        push_data_d  = push_data_q;
        push_nbits_d = push_nbits_q;
        push_last_d  = push_last_q;

        // The new bit lands just below the bits already collected; the
        // register is cleared at every word start, so lower bits stay zero.
        shreg_ins = shreg_q | (serin ? (MSB_ONE >> bitcnt_q) : '0);

        // Word output. A held full word always goes out on the cycle after
        // it completed. While one is held the bit counter is zero, so the
        // partial-word path can never fire at the same time.
        if (hold_vld_q) begin
            push_vld_d   = 1'b1;
            push_data_d  = hold_data_q;
            push_nbits_d = NBW'(WIDTH);
            push_last_d  = ~invalid;
        end else if ((state_q == S_COLLECT) && !invalid && (bitcnt_q != '0)) begin
            push_vld_d   = 1'b1;
            push_data_d  = shreg_q;
            push_nbits_d = bitcnt_q;
            push_last_d  = 1'b1;
        end

        // Bit collection
        if (invalid) begin
            state_d  = S_COLLECT;
            shreg_d  = shreg_ins;
            bitcnt_d = bitcnt_q + NBW'(1);
            if (bitcnt_q == NBW'(WIDTH - 1)) begin
                hold_vld_d  = 1'b1;
                hold_data_d = shreg_ins;
                shreg_d     = '0;
                bitcnt_d    = '0;
            end
        end else begin
            // Any idle cycle ends the frame.
            state_d  = S_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    assign pop        = out_valid_q & out_ready;
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot even when full.
    assign push_acc   = push_vld_q & (~full | pop);
    assign drop       = push_vld_q & full & ~pop;
    assign push_entry = {push_data_q, push_nbits_q, push_last_q};

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push_acc);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        overflow_d  = (overflow_q & ~clr_ovf) | drop;
        frames_d    = frames_q + CNTW'(push_acc & push_last_q);
        out_valid_d = (rd_ptr_d != wr_ptr_d);

        // The head for the next cycle is the incoming word when the FIFO
        // holds nothing else; otherwise it is already in memory.
        if (!out_valid_d) begin
            head_entry = '0;
        end else if (rd_ptr_d == wr_ptr_q) begin
            head_entry = push_entry;
        end else begin
            head_entry = mem_q[rd_ptr_d[AW-1:0]];
        end
        {out_data_d, out_nbits_d, out_last_d} = head_entry;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            push_vld_q   <= 1'b0;
            push_data_q  <= '0;
            push_nbits_q <= '0;
            push_last_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_nbits_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frames_q     <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            push_vld_q   <= push_vld_d;
            push_data_q  <= push_data_d;
            push_nbits_q <= push_nbits_d;
            push_last_q  <= push_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            out_nbits_q  <= out_nbits_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            frames_q     <= frames_d;
        end
    end

    // Storage array carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign out_data  = out_data_q;
    assign out_nbits = out_nbits_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign frames_rx = frames_q;

endmodule
